door_access_sequencer: RTL



---
 rtl/door_pkg.sv | 24 ++
 rtl/door_timer.sv | 42 ++++
 rtl/door_access_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/door_pkg.sv
// -----------------------------------------------------------------------------
// door_pkg
// Shared definitions for the access-door sequencer. The keypad front end and
// the benches reuse these definitions.
//   STATE_W       : width of the state encoding
//   door_state_e  : IDLE=00, OPEN=01, AJAR=10, LOCKOUT=11
//   max_int()     : elaboration-time helper used to size the shared timer
// -----------------------------------------------------------------------------
package door_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'b00,
        OPEN    = 2'b01,
        AJAR    = 2'b10,
        LOCKOUT = 2'b11
    } door_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/door_timer.sv
// -----------------------------------------------------------------------------
// door_timer
// Loadable down-counter with a zero flag. A load takes priority over counting.
// The counter stops at zero instead of wrapping.
//   clk, reset  : clock, synchronous active-high reset (count -> 0)
//   load        : load load_value this cycle
//   load_value  : value to load
//   zero        : count is zero
// -----------------------------------------------------------------------------
module door_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/door_access_sequencer.sv
// -----------------------------------------------------------------------------
// door_access_sequencer
// Checks a 4-bit keypad code on request, holds the door strobe open for a
// fixed window, raises an alarm while the door is left ajar, and locks the
// keypad out after MAX_FAILS consecutive wrong codes.
//   clk, reset        : clock, synchronous active-high reset
//   validate_code     : check access_code this cycle
//   access_code       : code presented by the keypad
//   door_closed       : door sensor, 1 = closed
//   open_access_door  : door actuator strobe (OPEN only)
//   alarm             : door-ajar alarm (AJAR only)
//   locked_out        : lockout indicator (LOCKOUT only)
//   state_out         : current state encoding
//   fail_count        : consecutive wrong-code count, saturating at MAX_FAILS
// -----------------------------------------------------------------------------
module door_access_sequencer
    import door_pkg::*;
#(
    parameter logic [3:0] CODE           = 4'd9,
    parameter int         MAX_FAILS      = 3,
    parameter int         OPEN_CYCLES    = 10,
    parameter int         LOCKOUT_CYCLES = 20
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           validate_code,
    input  logic [3:0]                     access_code,
    input  logic                           door_closed,
    output logic                           open_access_door,
    output logic                           alarm,
    output logic                           locked_out,
    output logic [STATE_W-1:0]             state_out,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

    localparam int FC_W      = $clog2(MAX_FAILS + 1);
    localparam int TMR_W_RAW = $clog2(max_int(OPEN_CYCLES, LOCKOUT_CYCLES));
    // Both windows of length 1 would give a zero-width timer; keep one bit.
    localparam int TMR_W     = (TMR_W_RAW < 1) ? 1 : TMR_W_RAW;

    localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FC_W-1:0]  FC_MAX    = FC_W'(MAX_FAILS);

    door_state_e      state_q, state_d;
    logic [FC_W-1:0]  fail_q,  fail_d;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_value;
    logic             tmr_zero;

    door_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .zero       (tmr_zero)
    );

    always_comb begin
        state_d        = state_q;
        fail_d         = fail_q;
        tmr_load       = 1'b0;
        tmr_load_value = '0;

        case (state_q)
            IDLE: begin
                if (validate_code) begin
                    if (access_code == CODE) begin
                        state_d        = OPEN;
                        fail_d         = '0;
                        tmr_load       = 1'b1;
                        tmr_load_value = OPEN_LOAD;
                    end else begin
                        if (fail_q != FC_MAX) begin
                            fail_d = fail_q + FC_W'(1);
                        end
                        if (fail_d == FC_MAX) begin
                            state_d        = LOCKOUT;
                            tmr_load       = 1'b1;
                            tmr_load_value = LOCK_LOAD;
                        end
                    end
                end
            end
            // The window is fixed: requests are ignored and never re-arm it.
            OPEN: begin
                if (tmr_zero) begin
                    state_d = door_closed ? IDLE : AJAR;
                end
            end
            AJAR: begin
                if (door_closed) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
        end
    end

    assign open_access_door = (state_q == OPEN);
    assign alarm            = (state_q == AJAR);
    assign locked_out       = (state_q == LOCKOUT);
    assign state_out        = state_q;
    assign fail_count       = fail_q;

endmodule
